// File: rtl/program_loader_pkg.sv
// Shared constants and state encoding for the boot-time program loader.
package program_loader_pkg;

    localparam int         DEFAULT_ROM_ADDRESS_BITWIDTH = 14;
    localparam logic [7:0] LOADER_ACK                   = 8'h06;
    localparam logic [7:0] LOADER_NAK                   = 8'h15;
    localparam int         LOADER_HEADER_BYTES          = 4;

    typedef enum logic [2:0] {
        LOADER_STATE_IDLE     = 3'd0,
        LOADER_STATE_HEADER   = 3'd1,
        LOADER_STATE_PAYLOAD  = 3'd2,
        LOADER_STATE_CHECKSUM = 3'd3,
        LOADER_STATE_SEND_ACK = 3'd4,
        LOADER_STATE_SEND_NAK = 3'd5,
        LOADER_STATE_DONE     = 3'd6,
        LOADER_STATE_ERROR    = 3'd7
    } loader_state_e;

endpackage

// File: rtl/program_loader_word_assembler.sv
// Shifts bytes into little-endian 32-bit words and keeps the payload XOR.
import program_loader_pkg::*;

module program_loader_word_assembler (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        byte_en_i,
    input  logic        xor_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        last_byte_o,
    output logic [7:0]  xor_o
);

    logic [23:0] word_q;
    logic [1:0]  cnt_q;
    logic [7:0]  xor_q;

    // Word including the byte on the input this cycle; complete when last_byte_o.
    assign word_o      = {byte_i, word_q};
    assign last_byte_o = (cnt_q == 2'(LOADER_HEADER_BYTES - 1));
    assign xor_o       = xor_q;

    // Byte shift-in, position counter and running checksum.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            word_q <= '0;
            cnt_q  <= '0;
            xor_q  <= '0;
        end else if (byte_en_i) begin
            word_q <= word_o[31:8];
            cnt_q  <= cnt_q + 2'd1;
            if (xor_en_i) xor_q <= xor_q ^ byte_i;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Boot loader: header/payload/checksum parser that writes the instruction ROM
// and keeps the CPU in reset until the image is verified.
import program_loader_pkg::*;

module program_loader #(
    parameter int ROM_ADDRESS_BITWIDTH = DEFAULT_ROM_ADDRESS_BITWIDTH
) (
    input  logic                            clk,
    input  logic                            reset_n,
    input  logic [7:0]                      rx_data,
    input  logic                            rx_valid,
    output logic                            rx_ready,
    output logic [7:0]                      tx_data,
    output logic                            tx_valid,
    input  logic                            tx_ready,
    output logic                            rom_wren,
    output logic [ROM_ADDRESS_BITWIDTH-1:0] rom_write_address,
    output logic [31:0]                     rom_write_data,
    output logic                            cpu_reset_n,
    output logic                            done,
    output logic                            error
);

    localparam int AW        = ROM_ADDRESS_BITWIDTH;
    localparam int MAX_WORDS = 2 ** (AW - 2);

    loader_state_e   state_q, state_d;
    logic [AW-2:0]   word_idx_q, word_idx_d;
    logic [AW-2:0]   word_total_q, word_total_d;
    logic            rom_wren_q;
    logic [AW-1:0]   rom_addr_q;
    logic [31:0]     rom_data_q;
    logic            tx_valid_q;
    logic [7:0]      tx_data_q;
    logic            wr_fire;
    logic            accept;
    logic            asm_en;
    logic            asm_xor_en;
    logic [31:0]     asm_word;
    logic            asm_last;
    logic [7:0]      asm_xor;

    assign rx_ready   = (state_q == LOADER_STATE_HEADER) || (state_q == LOADER_STATE_PAYLOAD) ||
                        (state_q == LOADER_STATE_CHECKSUM);
    assign accept     = rx_valid && rx_ready;
    assign asm_en     = accept && ((state_q == LOADER_STATE_HEADER) || (state_q == LOADER_STATE_PAYLOAD));
    assign asm_xor_en = (state_q == LOADER_STATE_PAYLOAD);

    program_loader_word_assembler u_asm (
        .clk         (clk),
        .reset_n     (reset_n),
        .byte_en_i   (asm_en),
        .xor_en_i    (asm_xor_en),
        .byte_i      (rx_data),
        .word_o      (asm_word),
        .last_byte_o (asm_last),
        .xor_o       (asm_xor)
    );

    // Next-state logic; header length is checked against capacity before any write.
    always_comb begin
        state_d      = state_q;
        word_idx_d   = word_idx_q;
        word_total_d = word_total_q;
        wr_fire      = 1'b0;
        unique case (state_q)
            LOADER_STATE_IDLE: state_d = LOADER_STATE_HEADER;
            LOADER_STATE_HEADER: begin
                if (accept && asm_last) begin
                    if (asm_word == 32'd0) begin
                        state_d = LOADER_STATE_CHECKSUM;
                    end else if (asm_word > 32'(MAX_WORDS)) begin
                        state_d = LOADER_STATE_SEND_NAK;
                    end else begin
                        word_total_d = asm_word[AW-2:0];
                        state_d      = LOADER_STATE_PAYLOAD;
                    end
                end
            end
            LOADER_STATE_PAYLOAD: begin
                if (accept && asm_last) begin
                    wr_fire    = 1'b1;
                    word_idx_d = word_idx_q + 1'b1;
                    if (word_idx_d == word_total_q) state_d = LOADER_STATE_CHECKSUM;
                end
            end
            LOADER_STATE_CHECKSUM: begin
                if (accept) state_d = (rx_data == asm_xor) ? LOADER_STATE_SEND_ACK : LOADER_STATE_SEND_NAK;
            end
            LOADER_STATE_SEND_ACK: if (tx_ready) state_d = LOADER_STATE_DONE;
            LOADER_STATE_SEND_NAK: if (tx_ready) state_d = LOADER_STATE_ERROR;
            default: state_d = state_q;
        endcase
    end

    // State, counters, ROM write register and TX status register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= LOADER_STATE_IDLE;
            word_idx_q   <= '0;
            word_total_q <= '0;
            rom_wren_q   <= 1'b0;
            rom_addr_q   <= '0;
            rom_data_q   <= '0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            word_idx_q   <= word_idx_d;
            word_total_q <= word_total_d;
            rom_wren_q   <= wr_fire;
            if (wr_fire) begin
                rom_addr_q <= {word_idx_q[AW-3:0], 2'b00};
                rom_data_q <= asm_word;
            end
            tx_valid_q <= (state_d == LOADER_STATE_SEND_ACK) || (state_d == LOADER_STATE_SEND_NAK);
            tx_data_q  <= (state_d == LOADER_STATE_SEND_ACK) ? LOADER_ACK :
                          (state_d == LOADER_STATE_SEND_NAK) ? LOADER_NAK : 8'h00;
        end
    end

    assign rom_wren          = rom_wren_q;
    assign rom_write_address = rom_addr_q;
    assign rom_write_data    = rom_data_q;
    assign tx_valid          = tx_valid_q;
    assign tx_data           = tx_data_q;
    assign cpu_reset_n       = (state_q == LOADER_STATE_DONE);
    assign done              = (state_q == LOADER_STATE_DONE);
    assign error             = (state_q == LOADER_STATE_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// Directed + randomized bench for program_loader with a byte-stream image model.
module tb_program_loader;

    localparam int AW   = 14;
    localparam int MAXW = 2 ** (AW - 2);

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [7:0]    rx_data = 8'h00;
    logic          rx_valid = 1'b0;
    logic          rx_ready;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready = 1'b0;
    logic          rom_wren;
    logic [AW-1:0] rom_write_address;
    logic [31:0]   rom_write_data;
    logic          cpu_reset_n;
    logic          done;
    logic          error;

    int checks = 0;
    int errors = 0;

    logic [31:0] img[$];
    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];

    program_loader #(.ROM_ADDRESS_BITWIDTH(AW)) dut (
        .clk(clk), .reset_n(reset_n),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rom_wren(rom_wren), .rom_write_address(rom_write_address), .rom_write_data(rom_write_data),
        .cpu_reset_n(cpu_reset_n), .done(done), .error(error)
    );

    always #5 clk = ~clk;

    // Record every ROM write for comparison against the image model.
    always @(negedge clk) begin
        if (rom_wren) begin
            got_addr.push_back(32'(rom_write_address));
            got_data.push_back(rom_write_data);
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        checks++;
        errors++;
        $error("FAIL %s observed=timeout expected=handshake", tag);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset_n  = 1'b0;
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        @(posedge clk); #1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_rx_ready", rx_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_rom_wren", rom_wren, 0);
        chk("rst_rom_addr", rom_write_address, 0);
        chk("rst_rom_data", rom_write_data, 0);
        chk("rst_cpu_reset_n", cpu_reset_n, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int max_gap);
        int  g;
        bit  ok;
        g = $urandom_range(max_gap, 0);
        rx_valid = 1'b0;
        repeat (g) begin @(posedge clk); #1; end
        rx_valid = 1'b1;
        rx_data  = b;
        ok = 0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (rx_ready) ok = 1;
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (!ok) timeout_fail("rx_accept");
    endtask

    // Full load of img[0..n-1] with header n; checksum is the XOR of payload
    // bytes modified by delta. Checks response, CPU release and ROM contents.
    task automatic load(input logic [31:0] n, input logic [7:0] delta, input int max_gap, input int hold);
        bit         over;
        bit         exp_ack;
        bit         seen;
        logic [7:0] x;
        logic [7:0] exp_tx;
        int         nw;
        over = (n > 32'(MAXW));
        nw   = over ? 0 : int'(n);
        x    = 8'h00;
        for (int k = 0; k < 4; k++) send_byte(n[8*k +: 8], max_gap);
        if (!over) begin
            for (int w = 0; w < nw; w++)
                for (int k = 0; k < 4; k++) begin
                    x ^= img[w][8*k +: 8];
                    send_byte(img[w][8*k +: 8], max_gap);
                end
            send_byte(x ^ delta, max_gap);
        end
        exp_ack = !over && (delta == 8'h00);
        exp_tx  = exp_ack ? 8'h06 : 8'h15;
        seen = 0;
        for (int t = 0; t < 100 && !seen; t++) begin
            @(negedge clk);
            if (tx_valid) seen = 1;
        end
        if (!seen) begin
            timeout_fail("tx_valid_wait");
            return;
        end
        chk("tx_data", tx_data, exp_tx);
        chk("cpu_held_before_ack", cpu_reset_n, 0);
        chk("rx_ready_while_tx", rx_ready, 0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("tx_valid_hold", tx_valid, 1);
            chk("tx_data_hold", tx_data, exp_tx);
        end
        @(posedge clk); #1;
        tx_ready = 1'b1;
        @(negedge clk);
        chk("tx_valid_at_hs", tx_valid, 1);
        chk("cpu_held_at_hs", cpu_reset_n, 0);
        @(posedge clk); #1;
        tx_ready = 1'b0;
        @(negedge clk);
        chk("cpu_reset_n_after", cpu_reset_n, 32'(exp_ack));
        chk("done_after", done, 32'(exp_ack));
        chk("error_after", error, 32'(!exp_ack));
        chk("tx_valid_after", tx_valid, 0);
        chk("rx_ready_after", rx_ready, 0);
        chk("wr_count", got_addr.size(), nw);
        for (int i = 0; i < nw && i < got_addr.size(); i++) begin
            chk("wr_addr", got_addr[i], 32'(i * 4));
            chk("wr_data", got_data[i], img[i]);
        end
        repeat (3) @(negedge clk);
        chk("state_sticky", {done, error, cpu_reset_n}, {exp_ack, !exp_ack, exp_ack});
    endtask

    task automatic rand_img(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    initial begin
        do_reset();

        // Two-instruction image, correct checksum.
        img.delete();
        img.push_back(32'h00000013);
        img.push_back(32'h00100093);
        load(32'd2, 8'h00, 0, 0);

        // Same image, corrupted checksum: writes still happen, then NAK.
        do_reset();
        load(32'd2, 8'h01, 2, 1);

        // Oversized headers: rejected right after the header, no writes.
        do_reset();
        load(32'(MAXW + 1), 8'h00, 1, 0);
        do_reset();
        load(32'hFFFF_FFFF, 8'h00, 0, 0);

        // Empty image: checksum must be 0x00.
        do_reset();
        load(32'd0, 8'h00, 1, 0);
        do_reset();
        load(32'd0, 8'h01, 1, 0);

        // Random gaps on rx and tx_ready held low for 5 cycles.
        do_reset();
        rand_img(5);
        load(32'd5, 8'h00, 3, 5);

        // Abort after two payload bytes, then a clean one-word load.
        do_reset();
        for (int k = 0; k < 4; k++) send_byte(8'(k == 0), 0);
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        do_reset();
        rand_img(1);
        load(32'd1, 8'h00, 1, 2);

        // Randomized images, mixed good/bad checksums.
        for (int r = 0; r < 4; r++) begin
            do_reset();
            rand_img($urandom_range(8, 1));
            load(32'(img.size()), (r % 2 == 0) ? 8'h00 : 8'($urandom_range(255, 1)), 2, $urandom_range(4, 0));
        end

        // Full-capacity image: last write lands at (MAXW-1)*4.
        do_reset();
        rand_img(MAXW);
        load(32'(MAXW), 8'h00, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
